// File: rtl/aes_axis_tx.sv
// AES result block serializer: queues 128-bit result blocks in a small FIFO and
// streams each one out as BLK_S/WORD_S words on an AXI4-Stream master.
module aes_axis_tx #(
    parameter int BLK_S      = 128,
    parameter int WORD_S     = 32,
    parameter int FIFO_DEPTH = 2,
    parameter bit SWAP_BYTES = 1'b1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [BLK_S-1:0]      blk_in_data,
    input  logic                  blk_in_last,
    input  logic                  blk_in_valid,
    output logic                  blk_in_ready,
    output logic [WORD_S-1:0]     m00_axis_tdata,
    output logic [WORD_S/8-1:0]   m00_axis_tkeep,
    output logic                  m00_axis_tlast,
    output logic                  m00_axis_tvalid,
    input  logic                  m00_axis_tready,
    output logic                  busy,
    output logic                  o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid never waits on ready and held data stays stable until taken.

    localparam int N      = BLK_S / WORD_S;
    localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N - 1);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [BLK_S:0]     r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic [PTR_W:0]     w_count_next;
    logic               r_in_ready;
    logic [BLK_S-1:0]   r_shift;
    logic               r_last;
    logic [CNT_W-1:0]   r_word_cnt;
    logic               w_push;
    logic               w_pop;
    logic               w_advance;
    logic               w_empty;
    logic               w_last_word;
    logic [BLK_S:0]     w_head;
    logic [WORD_S-1:0]  w_raw;
    logic [WORD_S-1:0]  w_word;

    assign w_push      = blk_in_valid && r_in_ready;
    assign w_empty     = (r_count == '0);
    assign w_last_word = (r_word_cnt == LAST_WORD);
    assign w_head      = r_mem[r_rd_ptr];

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + (PTR_W + 1)'(1);
            2'b01:   w_count_next = r_count - (PTR_W + 1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Ready is registered from the next occupancy, so a full FIFO never sees a push.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next != DEPTH_CNT);
        end
    end

    always_ff @(posedge aclk) begin
        if (w_push) r_mem[r_wr_ptr] <= {blk_in_last, blk_in_data};
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (m00_axis_tready) begin
                    if (!w_last_word) begin
                        w_advance = 1'b1;
                    end else if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // The current word always sits at the top of the shift register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_last     <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pop) begin
                r_shift    <= w_head[BLK_S-1:0];
                r_last     <= w_head[BLK_S];
                r_word_cnt <= '0;
            end else if (w_advance) begin
                r_shift    <= r_shift << WORD_S;
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
        end
    end

    assign w_raw = r_shift[BLK_S-1 -: WORD_S];

    generate
        if (SWAP_BYTES) begin : g_swap
            always_comb begin
                w_word = '0;
                for (int b = 0; b < WORD_S / 8; b++) begin
                    w_word[8*b +: 8] = w_raw[WORD_S-8-8*b +: 8];
                end
            end
        end else begin : g_noswap
            assign w_word = w_raw;
        end
    endgenerate

    assign blk_in_ready    = r_in_ready;
    assign m00_axis_tdata  = w_word;
    assign m00_axis_tkeep  = '1;
    assign m00_axis_tvalid = (r_state == S_SEND);
    assign m00_axis_tlast  = (r_state == S_SEND) && w_last_word && r_last;
    assign busy            = (r_state == S_SEND) || !w_empty;
    assign o_dbg_state     = (r_state == S_SEND);

endmodule

// File: tb/tb_aes_axis_tx.sv
// Bench for aes_axis_tx: byte-swapping and pass-through instances share the
// same stimulus and are checked against hand-computed words.
module tb_aes_axis_tx;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] blk_data;
  logic         blk_last;
  logic         blk_valid;
  logic         blk_ready, ns_blk_ready;
  logic [31:0]  tdata, ns_tdata;
  logic [3:0]   tkeep, ns_tkeep;
  logic         tlast, ns_tlast;
  logic         tvalid, ns_tvalid;
  logic         tready;
  logic         busy, ns_busy;
  logic         dbg, ns_dbg;

  logic [1:0]   tr_mode = 2'd0;  // 0 low, 1 high, 2 two-low/six-high
  logic [2:0]   tr_phase = 3'd0;

  int n_cmp = 0;
  int n_fail = 0;
  int hs_cnt = 0;
  int tlast_cnt = 0;
  int run_len = 0;
  int last_run = 0;
  int stall_cycles = 0;

  logic [64:0] exp_q[$];  // {tlast, swapped word, plain word}

  typedef struct {
    logic [127:0] blk;
    logic [127:0] sw;
  } vec_t;
  vec_t v[4];

  always #5 clk = ~clk;

  always @(posedge clk) tr_phase <= tr_phase + 3'd1;
  assign tready = (tr_mode == 2'd1) || ((tr_mode == 2'd2) && (tr_phase >= 3'd2));

  aes_axis_tx #(.BLK_S(128), .WORD_S(32), .FIFO_DEPTH(2), .SWAP_BYTES(1'b1)) dut (
    .aclk(clk), .aresetn(rst_n),
    .blk_in_data(blk_data), .blk_in_last(blk_last), .blk_in_valid(blk_valid),
    .blk_in_ready(blk_ready),
    .m00_axis_tdata(tdata), .m00_axis_tkeep(tkeep), .m00_axis_tlast(tlast),
    .m00_axis_tvalid(tvalid), .m00_axis_tready(tready),
    .busy(busy), .o_dbg_state(dbg)
  );

  aes_axis_tx #(.BLK_S(128), .WORD_S(32), .FIFO_DEPTH(2), .SWAP_BYTES(1'b0)) dut_ns (
    .aclk(clk), .aresetn(rst_n),
    .blk_in_data(blk_data), .blk_in_last(blk_last), .blk_in_valid(blk_valid),
    .blk_in_ready(ns_blk_ready),
    .m00_axis_tdata(ns_tdata), .m00_axis_tkeep(ns_tkeep), .m00_axis_tlast(ns_tlast),
    .m00_axis_tvalid(ns_tvalid), .m00_axis_tready(tready),
    .busy(ns_busy), .o_dbg_state(ns_dbg)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Scoreboard: a word is taken at the next rising edge when valid && ready here.
  always @(negedge clk) begin
    if (rst_n && tvalid && tready) begin
      logic [64:0] e;
      hs_cnt++;
      if (tlast) tlast_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_word: got %h, expected none", tdata);
      end else begin
        e = exp_q.pop_front();
        check("tdata_swap", {32'd0, tdata}, {32'd0, e[63:32]});
        check("tdata_noswap", {32'd0, ns_tdata}, {32'd0, e[31:0]});
        check("tlast", {63'd0, tlast}, {63'd0, e[64]});
      end
    end
    if (tvalid) run_len++;
    else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
  end

  task automatic push_exp(input int idx, input logic last);
    for (int k = 0; k < 4; k++)
      exp_q.push_back({(k == 3) && last, v[idx].sw[127-32*k -: 32], v[idx].blk[127-32*k -: 32]});
  endtask

  task automatic push_blk(input int idx, input logic last, input int max_c, input bit must, output bit ok);
    blk_data  = v[idx].blk;
    blk_last  = last;
    blk_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < max_c; c++) begin
      @(negedge clk);
      if (blk_ready) begin
        ok = 1'b1;
        break;
      end
      stall_cycles++;
    end
    @(posedge clk);
    #1;
    blk_valid = 1'b0;
    if (ok) push_exp(idx, last);
    else if (must) fail_now("push_timeout");
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ok;
    int base, acc;
    logic [31:0] held;

    v[0].blk = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    v[0].sw  = 128'hd8e0c469_30047b6a_80b7cdd8_5ac5b470;
    v[1].blk = 128'h00112233_44556677_8899aabb_ccddeeff;
    v[1].sw  = 128'h33221100_77665544_bbaa9988_ffeeddcc;
    v[2].blk = 128'h01234567_89abcdef_fedcba98_76543210;
    v[2].sw  = 128'h67452301_efcdab89_98badcfe_10325476;
    v[3].blk = 128'hdeadbeef_cafebabe_00000001_80000000;
    v[3].sw  = 128'hefbeadde_bebafeca_01000000_00000080;

    rst_n = 1'b0; blk_data = '0; blk_last = 1'b0; blk_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", {63'd0, tvalid}, 64'd0);
    check("rst_tlast", {63'd0, tlast}, 64'd0);
    check("rst_tdata", {32'd0, tdata}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_ready", {63'd0, blk_ready}, 64'd0);
    check("rst_tkeep", {60'd0, tkeep}, 64'hf);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ready_after_rst", {63'd0, blk_ready}, 64'd1);

    // T1/T5: single block, latency and word order for both byte orders
    tr_mode = 2'd1;
    base = tlast_cnt;
    push_blk(0, 1'b1, 20, 1'b1, ok);
    check("t1_tvalid_1cyc", {63'd0, tvalid}, 64'd0);
    @(posedge clk); #1;
    check("t1_tvalid_2cyc", {63'd0, tvalid}, 64'd1);
    check("t1_word0_swap", {32'd0, tdata}, 64'hd8e0c469);
    check("t5_word0_noswap", {32'd0, ns_tdata}, 64'h69c4e0d8);
    wait_idle();
    check("t1_tlast_count", tlast_cnt - base, 64'd1);

    // T2: back-to-back blocks stream without bubbles
    base = tlast_cnt;
    push_blk(1, 1'b0, 20, 1'b1, ok);
    push_blk(2, 1'b0, 20, 1'b1, ok);
    push_blk(3, 1'b1, 20, 1'b1, ok);
    wait_idle();
    @(posedge clk); #1;
    check("t2_valid_run", last_run, 64'd12);
    check("t2_tlast_count", tlast_cnt - base, 64'd1);

    // T3: oscillating backpressure, 8 blocks
    tr_mode = 2'd2;
    stall_cycles = 0;
    for (int i = 0; i < 8; i++) push_blk(i % 4, (i == 7), 100, 1'b1, ok);
    check("t3_ready_dropped", {63'd0, (stall_cycles > 0)}, 64'd1);
    wait_idle();
    tr_mode = 2'd1;

    // T4: full stall accepts exactly three blocks
    tr_mode = 2'd0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      push_blk(i, (i == 2), 6, 1'b0, ok);
      if (ok) acc++;
    end
    check("t4_accepted", acc, 64'd3);
    held = tdata;
    repeat (4) @(posedge clk);
    #1;
    check("t4_tvalid_held", {63'd0, tvalid}, 64'd1);
    check("t4_tdata_word0", {32'd0, tdata}, 64'hd8e0c469);
    check("t4_tdata_stable", {32'd0, tdata}, {32'd0, held});
    check("t4_ready_low", {63'd0, blk_ready}, 64'd0);
    tr_mode = 2'd1;
    wait_idle();

    // T6: reset mid-frame discards everything and drops tvalid at once
    base = hs_cnt;
    push_blk(0, 1'b1, 20, 1'b1, ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (hs_cnt == base + 2) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("t6_wait_word1");
    rst_n = 1'b0;
    #1;
    check("t6_tvalid_async", {63'd0, tvalid}, 64'd0);
    check("t6_busy_async", {63'd0, busy}, 64'd0);
    check("t6_tdata_async", {32'd0, tdata}, 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    base = hs_cnt;
    push_blk(1, 1'b1, 20, 1'b1, ok);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("t6_word_count", hs_cnt - base, 64'd4);
    check("t6_busy_after", {63'd0, busy}, 64'd0);
    check("t6_tvalid_after", {63'd0, tvalid}, 64'd0);
    check("sb_empty", exp_q.size(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
